// File: rtl/cnt_seq_pkg.sv
// rtl/cnt_seq_pkg.sv - shared types and constants for the programmable counter sequencer
package cnt_seq_pkg;

  localparam int CNT_SEQ_W = 3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // cnt_core operation codes
  localparam logic [1:0] CORE_HOLD = 2'd0;
  localparam logic [1:0] CORE_UP   = 2'd1;
  localparam logic [1:0] CORE_DOWN = 2'd2;
  localparam logic [1:0] CORE_LOAD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_HOLD,
    ST_DONE
  } cnt_seq_state_t;

  typedef struct packed {
    logic                 dir;
    logic [CNT_SEQ_W-1:0] lim;
    logic [3:0]           reps;
  } cnt_seq_seg_t;

  function automatic logic [1:0] step_op(input logic dir);
    return (dir == DIR_DOWN) ? CORE_DOWN : CORE_UP;
  endfunction

endpackage

// File: rtl/cnt_core.sv
// rtl/cnt_core.sv - W-bit wrapping counter register with hold/up/down/load and target compare
module cnt_core
  import cnt_seq_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   op,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] lim,
  output logic [W-1:0] cnt,
  output logic         at_lim
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      case (op)
        CORE_UP:   cnt <= cnt + W'(1);
        CORE_DOWN: cnt <= cnt - W'(1);
        CORE_LOAD: cnt <= load_val;
        default:   cnt <= cnt;
      endcase
    end
  end

  // Compared against the registered value so a step decision never sees its own result
  assign at_lim = (cnt == lim);

endmodule

// File: rtl/cnt_seq_ctrl.sv
// rtl/cnt_seq_ctrl.sv - slot-programmed up/down counter sequencer
// Optional pause/resume/abort HOLD state: CNT_SEQ_PAUSE_EN
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int W    = CNT_SEQ_W,
  parameter int NSEG = 4,
  localparam int AW  = $clog2(NSEG),
  localparam int LW  = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic          cfg_dir,
  input  logic [W-1:0]  cfg_lim,
  input  logic [3:0]    cfg_reps,
  input  logic [LW-1:0] len,
  input  logic          start,
  input  logic          stop,
  output logic [W-1:0]  cnt,
  output logic [AW-1:0] seg_idx,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  cnt_seq_state_t state_q, state_d;
  cnt_seq_seg_t   slots_q [NSEG];
  cnt_seq_seg_t   cur;

  logic [AW-1:0] seg_idx_d;
  logic [W-1:0]  base_q, base_d;
  logic [3:0]    rep_q, rep_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] len_sat;
  logic [1:0]    op;
  logic          at_lim;
  logic          last_seg;

  assign cur      = slots_q[seg_idx];
  assign len_sat  = (len > LW'(NSEG)) ? LW'(NSEG) : len;
  assign last_seg = (LW'(seg_idx) + LW'(1)) >= len_q;
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign done     = (state_q == ST_DONE);

  cnt_core #(.W(W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .load_val (base_q),
    .lim      (cur.lim),
    .cnt      (cnt),
    .at_lim   (at_lim)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    op        = CORE_HOLD;
    seg_idx_d = seg_idx;
    base_d    = base_q;
    rep_d     = rep_q;
    len_d     = len_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          len_d   = len_sat;
        end
      end
      ST_LOAD: begin
        seg_idx_d = '0;
        base_d    = cnt;
        rep_d     = '0;
        state_d   = (len_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        // A pause or abort must freeze the counter on the very edge it is seen
        if (stop) begin
`ifdef CNT_SEQ_PAUSE_EN
          state_d = ST_HOLD;
`else
          state_d = ST_IDLE;
`endif
        end else if (!at_lim) begin
          op = step_op(cur.dir);
        end else if (rep_q < cur.reps) begin
          op    = CORE_LOAD;
          rep_d = rep_q + 4'd1;
        end else if (!last_seg) begin
          seg_idx_d = seg_idx + AW'(1);
          base_d    = cnt;
          rep_d     = '0;
        end else begin
          state_d = ST_DONE;
        end
      end
`ifdef CNT_SEQ_PAUSE_EN
      ST_HOLD: begin
        if (stop)       state_d = ST_IDLE;
        else if (start) state_d = ST_RUN;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_idx <= '0;
      base_q  <= '0;
      rep_q   <= '0;
      len_q   <= '0;
      cfg_err <= 1'b0;
      for (int i = 0; i < NSEG; i++) begin
        slots_q[i] <= '{dir: DIR_UP, lim: '0, reps: '0};
      end
    end else begin
      seg_idx <= seg_idx_d;
      base_q  <= base_d;
      rep_q   <= rep_d;
      len_q   <= len_d;
      cfg_err <= cfg_we && busy;
      if (cfg_we && !busy) begin
        slots_q[cfg_addr] <= '{dir: cfg_dir, lim: cfg_lim, reps: cfg_reps};
      end
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb/tb_cnt_seq_ctrl.sv - directed scoreboard bench for cnt_seq_ctrl
module tb_cnt_seq_ctrl;
  import cnt_seq_pkg::*;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_addr = '0;
  logic         cfg_dir = 1'b0;
  logic [W-1:0] cfg_lim = '0;
  logic [3:0]   cfg_reps = '0;
  logic [2:0]   len = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] cnt;
  logic [1:0]   seg_idx;
  logic         busy, done, cfg_err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  cnt_seq_ctrl #(.W(W), .NSEG(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_dir  (cfg_dir),
    .cfg_lim  (cfg_lim),
    .cfg_reps (cfg_reps),
    .len      (len),
    .start    (start),
    .stop     (stop),
    .cnt      (cnt),
    .seg_idx  (seg_idx),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push(input int v);
    exp_q.push_back(W'(v));
  endtask

  task automatic wr(input logic [1:0] a, input logic d, input logic [W-1:0] l, input logic [3:0] r);
    cfg_we = 1'b1; cfg_addr = a; cfg_dir = d; cfg_lim = l; cfg_reps = r;
    cyc();
    cfg_we = 1'b0;
  endtask

  // Pulses start; returns in the LOAD cycle
  task automatic kick(input logic [2:0] n);
    start = 1'b1; len = n;
    cyc();
    start = 1'b0;
    chk("load_busy", busy, 1);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      cyc();
      chk("cnt", cnt, exp_q.pop_front());
    end
  endtask

  task automatic finish_chk(input logic [W-1:0] fin);
    cyc();
    chk("done", done, 1);
    chk("busy_at_done", busy, 0);
    chk("cnt_final", cnt, fin);
    cyc();
    chk("done_clear", done, 0);
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_seg_idx", seg_idx, 0);
    rst = 1'b1;
    cyc();

    // Two-segment program: up to 6, then down to 1 twice
    wr(0, DIR_UP, 6, 0);
    wr(1, DIR_DOWN, 1, 1);
    for (int v = 0; v <= 6; v++) push(v);
    push(6);
    for (int v = 5; v >= 1; v--) push(v);
    push(6);
    for (int v = 5; v >= 1; v--) push(v);
    kick(2); drain(); finish_chk(1);

    // Bring cnt to 5, then wrap 5 -> 2
    wr(0, DIR_UP, 5, 0);
    for (int v = 1; v <= 5; v++) push(v);
    kick(1); drain(); finish_chk(5);
    wr(0, DIR_UP, 2, 0);
    push(5); push(6); push(7); push(0); push(1); push(2);
    kick(1); drain(); finish_chk(2);

    // len=0: LOAD then DONE, cnt untouched
    kick(0); finish_chk(2);

    // len=7 saturates to 4 segments; slots 2,3 still hold reset values
    push(2); push(2); push(1); push(2); push(1); push(1); push(2);
    push(3); push(4); push(5); push(6); push(7); push(0); push(0);
    kick(7); drain();
    chk("sat_seg_idx", seg_idx, 3);
    finish_chk(0);

    // Slot write while busy is rejected and flagged
    push(0); push(1); push(2);
    kick(1);
    cfg_we = 1'b1; cfg_addr = 0; cfg_dir = DIR_DOWN; cfg_lim = 7; cfg_reps = 5;
    cyc();
    cfg_we = 1'b0;
    chk("cnt", cnt, exp_q.pop_front());
    chk("cfg_err_pulse", cfg_err, 1);
    cyc();
    chk("cnt", cnt, exp_q.pop_front());
    chk("cfg_err_clear", cfg_err, 0);
    drain(); finish_chk(2);
    push(2);
    kick(1); drain(); finish_chk(2);

    // Stop while running at cnt=3
    wr(0, DIR_UP, 6, 0);
    push(2); push(3);
    kick(1); drain();
    stop = 1'b1; cyc(); stop = 1'b0;
`ifdef CNT_SEQ_PAUSE_EN
    for (int i = 0; i < 4; i++) begin
      chk("hold_busy", busy, 1);
      chk("hold_cnt", cnt, 3);
      chk("hold_done", done, 0);
      cyc();
    end
    start = 1'b1; cyc(); start = 1'b0;
    chk("resume_cnt", cnt, 3);
    push(4); push(5); push(6);
    drain(); finish_chk(6);

    wr(0, DIR_UP, 1, 0);
    push(6); push(7);
    kick(1); drain();
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("hold2_busy", busy, 1);
    chk("hold2_cnt", cnt, 7);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cnt", cnt, 7);
    cyc();
    chk("abort_no_done", done, 0);

    push(7);
    kick(1); drain();
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("hold3_busy", busy, 1);
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("both_busy", busy, 0);
    chk("both_cnt", cnt, 7);
    cyc();
    chk("both_no_done", done, 0);

    wr(0, DIR_UP, 4, 0);
    push(7); push(0); push(1); push(2); push(3); push(4);
    kick(1); drain(); finish_chk(4);
`else
    for (int i = 0; i < 4; i++) begin
      chk("abort_busy", busy, 0);
      chk("abort_cnt", cnt, 3);
      chk("abort_done", done, 0);
      cyc();
    end
    wr(0, DIR_UP, 4, 0);
    push(3); push(4);
    kick(1); drain(); finish_chk(4);
`endif

    // Asynchronous reset mid-run at cnt=4 clears counter and slots
    wr(0, DIR_UP, 7, 0);
    push(4);
    kick(1); drain();
    #2 rst = 1'b0;
    #1;
    chk("arst_cnt", cnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    cyc();
    chk("arst_no_done", done, 0);
    rst = 1'b1;
    cyc();
    push(0);
    kick(1); drain(); finish_chk(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
